// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared widths, twiddle ROM and FSM encoding for the FFT-8 twiddle stage
package fft8_pkg;
  localparam int MAG_W  = 8;
  localparam int SM_W   = MAG_W + 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int OUT_W  = 2 * MAG_W + 2;

  // W8^k in sign-magnitude ([8]=sign); zero entries carry sign=0
  localparam logic [SM_W-1:0] TW_RE [0:7] = '{
    9'h0FF, 9'h0B5, 9'h000, 9'h1B5, 9'h1FF, 9'h1B5, 9'h000, 9'h0B5
  };
  localparam logic [SM_W-1:0] TW_IM [0:7] = '{
    9'h000, 9'h1B5, 9'h1FF, 9'h1B5, 9'h000, 9'h0B5, 9'h0FF, 9'h0B5
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACC   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/cmul_mag_mult_8.sv
// rtl/cmul_mag_mult_8.sv - sequential shift-add unsigned 8x8 multiplier, done pulses 8 cycles after start
module cmul_mag_mult_8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p,
  output logic        done
);
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  logic        busy;

  // The start edge already folds in b[0], so seven more steps land done on cycle start+8.
  always_ff @(posedge clk) begin
    if (rst) begin
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (mplier[0]) p <= p + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        p      <= b[0] ? {8'b0, a} : 16'b0;
        mcand  <= {7'b0, a, 1'b0};
        mplier <= {1'b0, b[7:1]};
        cnt    <= 3'd1;
        busy   <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/fft8_twiddle_cmul.sv
// rtl/fft8_twiddle_cmul.sv - x * W8^k using one shared sequential magnitude multiplier over 4 products
module fft8_twiddle_cmul
  import fft8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SM_W-1:0]  in_re,
  input  logic [SM_W-1:0]  in_im,
  input  logic [2:0]       tw_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_re,
  output logic [OUT_W-1:0] out_im
);
  state_t state, state_nxt;

  logic [SM_W-1:0]   ar, ai, wr, wi;
  logic [SM_W-1:0]   op_a, op_b;
  logic [1:0]        pcnt;
  logic [2:0]        wcnt;
  logic [PROD_W-1:0] prod;
  logic              mult_start, mult_done, prod_neg, accept;
  logic signed [OUT_W-1:0] acc_re, acc_im, acc_re_nxt, acc_im_nxt, mag_ext, term;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (wcnt == 3'(MAG_W - 2)) state_nxt = ST_ACC;
      ST_ACC:   state_nxt = (pcnt == 2'd3) ? ST_DONE : ST_START;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == ST_IDLE);
    out_valid  = (state == ST_DONE);
    mult_start = (state == ST_START);
  end

  // Product order: ar*wr, ai*wi, ar*wi, ai*wr
  always_comb begin
    op_a = ar;
    op_b = wr;
    case (pcnt)
      2'd1: begin op_a = ai; op_b = wi; end
      2'd2: begin op_a = ar; op_b = wi; end
      2'd3: begin op_a = ai; op_b = wr; end
      default: ;
    endcase
  end

  cmul_mag_mult_8 u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (mult_start),
    .a     (op_a[MAG_W-1:0]),
    .b     (op_b[MAG_W-1:0]),
    .p     (prod),
    .done  (mult_done)
  );

  // A zero magnitude is always treated as positive so -0 never perturbs the sums.
  assign prod_neg = (op_a[MAG_W] ^ op_b[MAG_W]) && (prod != '0);
  assign mag_ext  = {2'b00, prod};
  assign term     = prod_neg ? -mag_ext : mag_ext;

  always_comb begin
    acc_re_nxt = acc_re;
    acc_im_nxt = acc_im;
    case (pcnt)
      2'd0:    acc_re_nxt = acc_re + term;
      2'd1:    acc_re_nxt = acc_re - term;
      default: acc_im_nxt = acc_im + term;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar     <= '0;
      ai     <= '0;
      wr     <= '0;
      wi     <= '0;
      pcnt   <= '0;
      wcnt   <= '0;
      acc_re <= '0;
      acc_im <= '0;
      out_re <= '0;
      out_im <= '0;
    end else begin
      wcnt <= (state == ST_WAIT) ? wcnt + 3'd1 : 3'd0;
      if (accept) begin
        ar     <= in_re;
        ai     <= in_im;
        wr     <= TW_RE[tw_idx];
        wi     <= TW_IM[tw_idx];
        pcnt   <= '0;
        acc_re <= '0;
        acc_im <= '0;
      end
      if (state == ST_ACC && mult_done) begin
        acc_re <= acc_re_nxt;
        acc_im <= acc_im_nxt;
        pcnt   <= pcnt + 2'd1;
        // Separate output registers keep the result stable after the handshake.
        if (pcnt == 2'd3) begin
          out_re <= acc_re_nxt;
          out_im <= acc_im_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft8_twiddle_cmul.sv
// tb/tb_fft8_twiddle_cmul.sv - self-checking bench for fft8_twiddle_cmul
module tb_fft8_twiddle_cmul;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_re = '0;
  logic [8:0]  in_im = '0;
  logic [2:0]  tw_idx = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [17:0] out_re;
  logic [17:0] out_im;

  fft8_twiddle_cmul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .tw_idx    (tw_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] re;
    logic [8:0] im;
    logic [2:0] k;
    int         exp_re;
    int         exp_im;
  } vec_t;

  typedef struct {
    int re;
    int im;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_out = 0;
  exp_t sb[$];
  vec_t vecs[7];
  int   wr_t[8] = '{255, 181, 0, -181, -255, -181, 0, 181};
  int   wi_t[8] = '{0, -181, -255, -181, 0, 181, 255, 181};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sm2i(input logic [8:0] v);
    int m;
    m = int'(v[7:0]);
    return v[8] ? -m : m;
  endfunction

  function automatic exp_t model(input logic [8:0] re, input logic [8:0] im, input logic [2:0] k);
    exp_t e;
    e.re = sm2i(re) * wr_t[k] - sm2i(im) * wi_t[k];
    e.im = sm2i(re) * wi_t[k] + sm2i(im) * wr_t[k];
    return e;
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk); #1;
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) check("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        check("out_re", int'($signed(out_re)), e.re);
        check("out_im", int'($signed(out_im)), e.im);
      end
    end
  end

  task automatic send(input logic [8:0] re, input logic [8:0] im, input logic [2:0] k,
                      input int exp_re, input int exp_im, output int t_acc);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_re = re; in_im = im; tw_idx = k;
    #1;
    while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
    t_acc = cyc;
    if (!in_ready) check("accept_timeout", 0, 1);
    else sb.push_back('{exp_re, exp_im});
    @(negedge clk);
    in_valid = 1'b0;
    in_re = 9'($urandom); in_im = 9'($urandom); tw_idx = 3'($urandom);
  endtask

  task automatic wait_out(input int t_acc, input bit chk_lat);
    int n = 0;
    #1;
    while (!out_valid && n < 100) begin @(negedge clk); #1; n++; end
    check("out_valid_seen", int'(out_valid), 1);
    if (out_valid && chk_lat) check("latency", cyc - t_acc, 37);
  endtask

  task automatic after_handshake();
    @(negedge clk); #1;
    check("out_valid_drop", int'(out_valid), 0);
    check("in_ready_back", int'(in_ready), 1);
  endtask

  initial begin
    int ta, tb, n, seen;
    exp_t e;
    logic [17:0] hold_re, hold_im;
    logic [8:0] rr, ri;
    logic [2:0] rk;

    vecs[0] = '{9'h064, 9'h132, 3'd0, 25500, -12750};
    vecs[1] = '{9'h00A, 9'h014, 3'd2, 5100, -2550};
    vecs[2] = '{9'h1FF, 9'h1FF, 3'd1, -92310, 0};
    vecs[3] = '{9'h100, 9'h001, 3'd3, 181, -181};
    vecs[4] = '{9'h003, 9'h107, 3'd5, 724, 1810};
    vecs[5] = '{9'h180, 9'h07F, 3'd6, -32385, -32640};
    vecs[6] = '{9'h0FF, 9'h000, 3'd4, -65025, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_re", int'($signed(out_re)), 0);
    check("reset_out_im", int'($signed(out_im)), 0);

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].re, vecs[i].im, vecs[i].k, vecs[i].exp_re, vecs[i].exp_im, ta);
      wait_out(ta, 1'b1);
      after_handshake();
    end

    for (int i = 0; i < 6; i++) begin
      rr = 9'($urandom); ri = 9'($urandom); rk = 3'($urandom);
      e = model(rr, ri, rk);
      send(rr, ri, rk, e.re, e.im, ta);
      wait_out(ta, 1'b1);
      after_handshake();
    end

    out_ready = 1'b0;
    send(vecs[0].re, vecs[0].im, vecs[0].k, vecs[0].exp_re, vecs[0].exp_im, ta);
    wait_out(ta, 1'b1);
    hold_re = out_re; hold_im = out_im;
    check("bp_value_re", int'($signed(hold_re)), vecs[0].exp_re);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_re_stable", int'($signed(out_re)), int'($signed(hold_re)));
      check("bp_out_im_stable", int'($signed(out_im)), int'($signed(hold_im)));
    end
    @(negedge clk);
    out_ready = 1'b1;
    after_handshake();
    check("hold_after_handshake", int'($signed(out_re)), vecs[0].exp_re);

    n = n_out; seen = 0; tb = 0;
    @(negedge clk);
    in_valid = 1'b1; in_re = vecs[1].re; in_im = vecs[1].im; tw_idx = vecs[1].k;
    for (int c = 0; c < 300 && n_out < n + 3; c++) begin
      #1;
      if (in_valid && in_ready) begin
        if (seen > 0) check("b2b_gap", cyc - tb, 38);
        tb = cyc;
        sb.push_back('{vecs[seen + 1].exp_re, vecs[seen + 1].exp_im});
        seen++;
      end
      @(negedge clk);
      if (seen < 3) begin
        in_re = vecs[seen + 1].re; in_im = vecs[seen + 1].im; tw_idx = vecs[seen + 1].k;
      end else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_accepts", seen, 3);
    check("b2b_outputs", n_out - n, 3);

    send(vecs[2].re, vecs[2].im, vecs[2].k, vecs[2].exp_re, vecs[2].exp_im, ta);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (sb.size() > 0) void'(sb.pop_back());
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_re", int'($signed(out_re)), 0);
    check("rst_out_im", int'($signed(out_im)), 0);
    seen = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("no_out_after_reset", seen, 0);
    send(9'h001, 9'h000, 3'd7, 181, 181, ta);
    wait_out(ta, 1'b1);
    after_handshake();

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1);
  end
endmodule
